// File: rtl/peri_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding, default
// error word and the well-known requester slots.
`ifndef PERI_BUS_ARBITER_DEFS
`define PERI_BUS_ARBITER_DEFS
`define MST_CORE 0
`define MST_DBG  1
`endif

package peri_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam int          DATA_W       = 32;
  localparam int          STRB_W       = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/peri_rr_pick.sv
// Rotate-priority encoder: first set request searching upward from last+1,
// wrapping modulo NUM_MST.
module peri_rr_pick #(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_MST);

  logic [IDX_W:0] sum;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int off = NUM_MST; off > 0; off--) begin
      sum = {1'b0, last} + (IDX_W+1)'(off);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      if (req[sum[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between NUM_MST requesters,
// one transaction in flight, with a per-transaction watchdog.
module peri_bus_arbiter
  import peri_bus_arbiter_pkg::*;
#(
  parameter int               NUM_MST  = 2,
  parameter int               CNT_W    = 8,
  parameter logic [CNT_W-1:0] TIMEOUT  = 8'd200,
  parameter logic [31:0]      ERR_DATA = ERR_DATA_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_MST-1:0]    m_rden_i,
  input  logic [NUM_MST-1:0]    m_wren_i,
  input  logic [NUM_MST*32-1:0] m_addr_i,
  input  logic [NUM_MST*32-1:0] m_wdata_i,
  input  logic [NUM_MST*4-1:0]  m_wstrb_i,
  output logic [NUM_MST-1:0]    m_ready_o,
  output logic [NUM_MST-1:0]    m_err_o,
  output logic [31:0]           m_rdata_o,
  output logic                  peri_rden_o,
  output logic                  peri_wren_o,
  output logic [31:0]           peri_addr_o,
  output logic [31:0]           peri_wdata_o,
  output logic [3:0]            peri_wstrb_o,
  input  logic                  peri_ready_i,
  input  logic [31:0]           peri_rdata_i
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               is_wr_q, is_wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_MST-1:0] req;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_MST-1:0] grant_oh;

  assign req = m_rden_i | m_wren_i;

  peri_rr_pick #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = m_addr_i[pick_idx*DATA_W +: DATA_W];
          wdata_d = m_wdata_i[pick_idx*DATA_W +: DATA_W];
          wstrb_d = m_wstrb_i[pick_idx*STRB_W +: STRB_W];
          is_wr_d = m_wren_i[pick_idx];
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A genuine answer beats the watchdog when both land together.
        if (peri_ready_i) begin
          rdata_d = is_wr_q ? '0 : peri_rdata_i;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if ((TIMEOUT != '0) && (cnt_q == TIMEOUT - 1'b1)) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MST - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign grant_oh     = NUM_MST'(1) << grant_q;
  assign peri_rden_o  = (state_q == ST_BUSY) && !is_wr_q;
  assign peri_wren_o  = (state_q == ST_BUSY) && is_wr_q;
  assign peri_addr_o  = addr_q;
  assign peri_wdata_o = wdata_q;
  assign peri_wstrb_o = wstrb_q;
  assign m_ready_o    = (state_q == ST_DONE) ? grant_oh : '0;
  assign m_err_o      = ((state_q == ST_DONE) && err_q) ? grant_oh : '0;
  assign m_rdata_o    = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Self-checking bench for peri_bus_arbiter: table-driven transactions plus
// hand-written reset, round-robin and idle-ready sequences, scoreboard on pulses.
module tb_peri_bus_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  m_rden_i;
  logic [1:0]  m_wren_i;
  logic [63:0] m_addr_i;
  logic [63:0] m_wdata_i;
  logic [7:0]  m_wstrb_i;
  logic [1:0]  m_ready_o;
  logic [1:0]  m_err_o;
  logic [31:0] m_rdata_o;
  logic        peri_rden_o;
  logic        peri_wren_o;
  logic [31:0] peri_addr_o;
  logic [31:0] peri_wdata_o;
  logic [3:0]  peri_wstrb_o;
  logic        peri_ready_i;
  logic [31:0] peri_rdata_i;

  typedef struct {
    int          mst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          mst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rsp;
    logic        drop;
    logic        exp_wr;
    int          exp_busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t expq[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  peri_bus_arbiter #(
    .NUM_MST  (2),
    .CNT_W    (8),
    .TIMEOUT  (8'd200),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_rden_i     (m_rden_i),
    .m_wren_i     (m_wren_i),
    .m_addr_i     (m_addr_i),
    .m_wdata_i    (m_wdata_i),
    .m_wstrb_i    (m_wstrb_i),
    .m_ready_o    (m_ready_o),
    .m_err_o      (m_err_o),
    .m_rdata_o    (m_rdata_o),
    .peri_rden_o  (peri_rden_o),
    .peri_wren_o  (peri_wren_o),
    .peri_addr_o  (peri_addr_o),
    .peri_wdata_o (peri_wdata_o),
    .peri_wstrb_o (peri_wstrb_o),
    .peri_ready_i (peri_ready_i),
    .peri_rdata_i (peri_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input int mst, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    m_rden_i[mst]           = rd;
    m_wren_i[mst]           = wr;
    m_addr_i[mst*32 +: 32]  = addr;
    m_wdata_i[mst*32 +: 32] = wdata;
    m_wstrb_i[mst*4 +: 4]   = wstrb;
  endtask

  task automatic releaseMaster(input int mst);
    m_rden_i[mst] = 1'b0;
    m_wren_i[mst] = 1'b0;
  endtask

  task automatic pushExpect(input int mst, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.mst   = mst;
    e.rdata = rdata;
    e.err   = err;
    expq.push_back(e);
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (m_ready_o != 2'b00) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected m_ready_o", 32'(m_ready_o), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("pulse master", 32'(m_ready_o), 32'd1 << mon_e.mst);
        checkOutput("pulse err", 32'(m_err_o), mon_e.err ? (32'd1 << mon_e.mst) : 32'd0);
        checkOutput("pulse rdata", m_rdata_o, mon_e.rdata);
      end
    end else begin
      checkOutput("m_rdata_o idle", m_rdata_o, 32'd0);
      checkOutput("m_err_o idle", 32'(m_err_o), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int  gap;
    int  waitCnt;
    int  busy;
    bit  seen;

    rst_i        = 1'b1;
    m_rden_i     = '0;
    m_wren_i     = '0;
    m_addr_i     = '0;
    m_wdata_i    = '0;
    m_wstrb_i    = '0;
    peri_ready_i = 1'b0;
    peri_rdata_i = '0;

    //          mst rd    wr    addr          wdata         wstrb  dly  rsp           drop  exp_wr busy exp_rdata     err
    vecs[0] = '{0, 1'b1, 1'b0, 32'h0001_0004, 32'h0,        4'h0,  3,   32'h1234_5678, 1'b0, 1'b0, 4,   32'h1234_5678, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'h3, 0,   32'hFFFF_FFFF, 1'b0, 1'b1, 1,   32'h0,         1'b0};
    vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0040, 32'h0102_0304, 4'hF, 2,   32'h5555_5555, 1'b0, 1'b1, 3,   32'h0,         1'b0};
    vecs[3] = '{1, 1'b1, 1'b0, 32'h3000_0000, 32'h0,        4'h0,  5,   32'h8000_0001, 1'b1, 1'b0, 6,   32'h8000_0001, 1'b0};
    vecs[4] = '{1, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0,        4'h0,  -1,  32'h0,         1'b0, 1'b0, 200, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,        4'h0,  199, 32'hA5A5_A5A5, 1'b0, 1'b0, 200, 32'hA5A5_A5A5, 1'b0};
    vecs[6] = '{0, 1'b0, 1'b1, 32'h0000_0100, 32'h7777_7777, 4'h8, -1,  32'h0,         1'b0, 1'b1, 200, 32'hDEAD_BEEF, 1'b1};

    repeat (2) @(negedge clk_i);
    checkOutput("reset m_ready_o", 32'(m_ready_o), 32'd0);
    checkOutput("reset m_err_o", 32'(m_err_o), 32'd0);
    checkOutput("reset m_rdata_o", m_rdata_o, 32'd0);
    checkOutput("reset peri_rden_o", 32'(peri_rden_o), 32'd0);
    checkOutput("reset peri_wren_o", 32'(peri_wren_o), 32'd0);
    checkOutput("reset peri_addr_o", peri_addr_o, 32'd0);
    checkOutput("reset peri_wdata_o", peri_wdata_o, 32'd0);
    checkOutput("reset peri_wstrb_o", 32'(peri_wstrb_o), 32'd0);
    rst_i = 1'b0;

    // Both masters hold read requests: grants must alternate 0,1,0,1 and
    // the bus stays idle for the DONE cycle plus the IDLE arbitration cycle.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) pushExpect(i % 2, 32'h1000_0000 + i, 1'b0);
    gap = 1;
    for (int i = 0; i < 4; i++) begin
      waitCnt = 0;
      while (!peri_rden_o && waitCnt < 20) begin
        @(negedge clk_i);
        if (!peri_rden_o) gap++;
        waitCnt++;
      end
      checkOutput($sformatf("rr%0d request seen", i), 32'(peri_rden_o), 32'd1);
      if (i > 0) checkOutput($sformatf("rr%0d idle gap", i), gap, 32'd2);
      checkOutput($sformatf("rr%0d grant addr", i), peri_addr_o,
                  (i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
      peri_ready_i = 1'b1;
      peri_rdata_i = 32'h1000_0000 + i;
      @(negedge clk_i);
      peri_ready_i = 1'b0;
      checkOutput($sformatf("rr%0d pulse", i), 32'(m_ready_o), 32'd1 << (i % 2));
      checkOutput($sformatf("rr%0d rden dropped", i), 32'(peri_rden_o), 32'd0);
      gap = 1;
    end
    releaseMaster(0);
    releaseMaster(1);

    for (int v = 0; v < 7; v++) begin
      @(negedge clk_i);
      applyStimulus(vecs[v].mst, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
      pushExpect(vecs[v].mst, vecs[v].exp_rdata, vecs[v].exp_err);
      busy = 0;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
        @(negedge clk_i);
        peri_ready_i = 1'b0;
        if (m_ready_o != 2'b00) begin
          seen = 1'b1;
        end else if (peri_rden_o || peri_wren_o) begin
          busy++;
          if (busy == 1) begin
            checkOutput($sformatf("vec%0d rden", v), 32'(peri_rden_o), 32'(!vecs[v].exp_wr));
            checkOutput($sformatf("vec%0d wren", v), 32'(peri_wren_o), 32'(vecs[v].exp_wr));
            checkOutput($sformatf("vec%0d addr", v), peri_addr_o, vecs[v].addr);
            checkOutput($sformatf("vec%0d wdata", v), peri_wdata_o, vecs[v].wdata);
            checkOutput($sformatf("vec%0d wstrb", v), 32'(peri_wstrb_o), 32'(vecs[v].wstrb));
            if (vecs[v].drop) releaseMaster(vecs[v].mst);
          end
          if (vecs[v].delay >= 0 && busy == vecs[v].delay + 1) begin
            peri_ready_i = 1'b1;
            peri_rdata_i = vecs[v].rsp;
          end
        end
      end
      checkOutput($sformatf("vec%0d pulse seen", v), 32'(seen), 32'd1);
      checkOutput($sformatf("vec%0d busy cycles", v), busy, vecs[v].exp_busy);
      checkOutput($sformatf("vec%0d pulse master", v), 32'(m_ready_o), 32'd1 << vecs[v].mst);
      checkOutput($sformatf("vec%0d request gap", v), 32'({peri_rden_o, peri_wren_o}), 32'd0);
      releaseMaster(vecs[v].mst);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d pulse single", v), 32'(m_ready_o), 32'd0);
    end

    // peri_ready_i with nothing in flight must be ignored.
    @(negedge clk_i);
    peri_ready_i = 1'b1;
    peri_rdata_i = 32'hFFFF_0000;
    @(negedge clk_i);
    peri_ready_i = 1'b0;
    checkOutput("idle ready no request", 32'({peri_rden_o, peri_wren_o}), 32'd0);
    @(negedge clk_i);
    checkOutput("idle ready no pulse", 32'(m_ready_o), 32'd0);

    // Reset in the middle of a write: request drops, no pulse, master 0 wins after.
    applyStimulus(1, 1'b0, 1'b1, 32'h4000_0000, 32'hABCD_0123, 4'hF);
    waitCnt = 0;
    while (!peri_wren_o && waitCnt < 20) begin
      @(negedge clk_i);
      waitCnt++;
    end
    checkOutput("rst write started", 32'(peri_wren_o), 32'd1);
    rst_i = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    @(negedge clk_i);
    checkOutput("rst drops wren", 32'(peri_wren_o), 32'd0);
    checkOutput("rst no pulse", 32'(m_ready_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    pushExpect(0, 32'h0BAD_CAFE, 1'b0);
    @(negedge clk_i);
    checkOutput("post-rst m0 rden", 32'(peri_rden_o), 32'd1);
    checkOutput("post-rst wren low", 32'(peri_wren_o), 32'd0);
    checkOutput("post-rst m0 addr", peri_addr_o, 32'h5000_0000);
    peri_ready_i = 1'b1;
    peri_rdata_i = 32'h0BAD_CAFE;
    @(negedge clk_i);
    peri_ready_i = 1'b0;
    checkOutput("post-rst pulse", 32'(m_ready_o), 32'd1);
    releaseMaster(0);
    releaseMaster(1);

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard drained", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
